// File: rtl/host_sched_pkg.sv
// Shared types and sizes for the host descriptor scheduler.
package host_sched_pkg;

    localparam int unsigned DESC_W     = 24;
    localparam int unsigned WEIGHT_W   = 4;
    localparam int unsigned USEDW_W    = 5;
    localparam int unsigned FIFO_AFULL = 14;
    localparam int unsigned STAT_W     = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_e;

    typedef enum logic {
        SRC_HCP = 1'b0,
        SRC_NET = 1'b1
    } src_e;

    // A zero weight still earns one grant per turn.
    function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
        return (w == '0) ? WEIGHT_W'(1) : w;
    endfunction

    function automatic src_e other_src(input src_e s);
        return (s == SRC_HCP) ? SRC_NET : SRC_HCP;
    endfunction

endpackage

// File: rtl/hds_credit_ctrl.sv
// Priority owner and consecutive-grant credit for the weighted round-robin.
module hds_credit_ctrl
    import host_sched_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_grant,
    input  src_e                i_winner,
    input  logic [WEIGHT_W-1:0] iv_weight_hcp,
    input  logic [WEIGHT_W-1:0] iv_weight_network,
    output src_e                o_owner
);

    src_e                owner_q, owner_d;
    logic [WEIGHT_W-1:0] credit_q, credit_d;
    logic [WEIGHT_W-1:0] credit_next_c;
    logic [WEIGHT_W-1:0] quota_c;

    // Winner's quota is sampled at grant time; exhausting it hands ownership over.
    always_comb begin
        owner_d       = owner_q;
        credit_d      = credit_q;
        credit_next_c = (i_winner == owner_q) ? credit_q + WEIGHT_W'(1) : WEIGHT_W'(1);
        quota_c       = eff_weight((i_winner == SRC_HCP) ? iv_weight_hcp : iv_weight_network);
        if (i_grant) begin
            if (credit_next_c >= quota_c) begin
                owner_d  = other_src(i_winner);
                credit_d = '0;
            end else begin
                owner_d  = i_winner;
                credit_d = credit_next_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            owner_q  <= SRC_HCP;
            credit_q <= '0;
        end else begin
            owner_q  <= owner_d;
            credit_q <= credit_d;
        end
    end

    assign o_owner = owner_q;

endmodule

// File: rtl/host_descriptor_scheduler.sv
// Weighted round-robin writer of the host descriptor FIFO for the HCP and network ports.
// Optional grant counters are built when HDS_STAT_EN is defined.
module host_descriptor_scheduler
    import host_sched_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [DESC_W-1:0]   iv_descriptor_hcp,
    input  logic                i_descriptor_wr_hcp,
    output logic                o_descriptor_ack_hcp,
    input  logic [DESC_W-1:0]   iv_descriptor_network,
    input  logic                i_descriptor_wr_network,
    output logic                o_descriptor_ack_network,
    input  logic [WEIGHT_W-1:0] iv_weight_hcp,
    input  logic [WEIGHT_W-1:0] iv_weight_network,
    input  logic [USEDW_W-1:0]  iv_fifo_usedw,
    output logic [DESC_W-1:0]   ov_fifo_wdata,
    output logic                o_fifo_wr
`ifdef HDS_STAT_EN
    ,
    output logic [STAT_W-1:0]   ov_grant_cnt_hcp,
    output logic [STAT_W-1:0]   ov_grant_cnt_network
`endif
);

    state_e              state_q, state_d;
    logic                wr_q, wr_d;
    logic                ack_hcp_q, ack_hcp_d;
    logic                ack_net_q, ack_net_d;
    logic [DESC_W-1:0]   wdata_q, wdata_d;
    logic                grant_c;
    src_e                winner_c;
    src_e                owner;
    logic                space_c;

    assign space_c = (iv_fifo_usedw < USEDW_W'(FIFO_AFULL));

    hds_credit_ctrl u_credit (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_grant           (grant_c),
        .i_winner          (winner_c),
        .iv_weight_hcp     (iv_weight_hcp),
        .iv_weight_network (iv_weight_network),
        .o_owner           (owner)
    );

    // Arbitrate in S_IDLE; S_WAIT covers the cycle the requester still sees its ack.
    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        ack_hcp_d = 1'b0;
        ack_net_d = 1'b0;
        wdata_d   = wdata_q;
        grant_c   = 1'b0;
        winner_c  = owner;
        case (state_q)
            S_IDLE: begin
                if (space_c && (i_descriptor_wr_hcp || i_descriptor_wr_network)) begin
                    grant_c = 1'b1;
                    if (owner == SRC_HCP) begin
                        winner_c = i_descriptor_wr_hcp ? SRC_HCP : SRC_NET;
                    end else begin
                        winner_c = i_descriptor_wr_network ? SRC_NET : SRC_HCP;
                    end
                    wr_d = 1'b1;
                    if (winner_c == SRC_HCP) begin
                        ack_hcp_d = 1'b1;
                        wdata_d   = iv_descriptor_hcp;
                    end else begin
                        ack_net_d = 1'b1;
                        wdata_d   = iv_descriptor_network;
                    end
                    state_d = S_WAIT;
                end
            end
            S_WAIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            wr_q      <= 1'b0;
            ack_hcp_q <= 1'b0;
            ack_net_q <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            ack_hcp_q <= ack_hcp_d;
            ack_net_q <= ack_net_d;
            wdata_q   <= wdata_d;
        end
    end

    assign o_fifo_wr                = wr_q;
    assign o_descriptor_ack_hcp     = ack_hcp_q;
    assign o_descriptor_ack_network = ack_net_q;
    assign ov_fifo_wdata            = wdata_q;

`ifdef HDS_STAT_EN
    logic [STAT_W-1:0] cnt_hcp_q, cnt_hcp_d;
    logic [STAT_W-1:0] cnt_net_q, cnt_net_d;

    // Counters advance together with the ack they count and wrap freely.
    always_comb begin
        cnt_hcp_d = cnt_hcp_q + STAT_W'(ack_hcp_d);
        cnt_net_d = cnt_net_q + STAT_W'(ack_net_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_hcp_q <= '0;
            cnt_net_q <= '0;
        end else begin
            cnt_hcp_q <= cnt_hcp_d;
            cnt_net_q <= cnt_net_d;
        end
    end

    assign ov_grant_cnt_hcp     = cnt_hcp_q;
    assign ov_grant_cnt_network = cnt_net_q;
`endif

endmodule
